// File: rtl/thermal_scan_sequencer_pkg.sv
// Shared types and default thresholds for the thermal scan sequencer.
package thermal_pkg;

  typedef logic [7:0] temp_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    EVAL  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam temp_t MIN_TEMP      = 8'd100;
  localparam temp_t ALARM_TEMP    = 8'd200;
  localparam temp_t SHUTDOWN_TEMP = 8'd250;

endpackage

// File: rtl/thermal_scan_sequencer_ch_monitor.sv
// Per-channel alarm persistence tracker.
// Optional macro THERM_HYST_EN: once raised, the flag holds through samples
// in ALARM_TEMP-HYST .. ALARM_TEMP-1 instead of clearing below ALARM_TEMP.
module thermal_ch_monitor
  import thermal_pkg::*;
#(
  parameter temp_t MIN_TEMP   = thermal_pkg::MIN_TEMP,
  parameter temp_t ALARM_TEMP = thermal_pkg::ALARM_TEMP,
  parameter int    PERSIST    = 3,
  parameter temp_t HYST       = 8'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,     // non-shutdown sample for this channel
  input  logic       clr,     // shutdown sample on any channel
  input  logic [7:0] sample,
  output logic       flag
);

`ifdef THERM_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  localparam int            PW      = $clog2(PERSIST + 1);
  localparam logic [PW-1:0] P_MAX   = PW'(PERSIST);
  localparam temp_t         BAND    = HYST_ON ? HYST : 8'd0;
  localparam temp_t         HOLD_LO = ALARM_TEMP - BAND;

  logic [PW-1:0] persist;
  logic [PW-1:0] p_next;
  logic          hi;
  logic          hold;

  // Saturating increment, and the band in which a raised flag is kept.
  // With hysteresis off, HOLD_LO equals ALARM_TEMP so hold never applies
  // to a below-alarm sample.
  always_comb begin
    hi     = sample >= ALARM_TEMP;
    hold   = flag && (sample >= HOLD_LO) && (sample >= MIN_TEMP);
    p_next = (persist == P_MAX) ? persist : persist + 1'b1;
  end

  // Persistence counter and alarm flag update on each qualified sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      persist <= '0;
      flag    <= 1'b0;
    end else if (clr) begin
      flag <= 1'b0;
    end else if (hit) begin
      if (hi) begin
        persist <= p_next;
        if (p_next == P_MAX) flag <= 1'b1;
      end else if (!hold) begin
        persist <= '0;
        flag    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/thermal_scan_sequencer.sv
// Round-robin thermal sensor scanner over one shared ADC.
// Optional macro THERM_HYST_EN enables alarm hysteresis in the channel monitors.
// Sample classification is registered on the adc_done edge, so temp_valid,
// underrange, shutdown and alarm_mask are all visible during the EVAL cycle.
module thermal_scan_sequencer
  import thermal_pkg::*;
#(
  parameter int    NUM_CH        = 4,
  parameter int    CH_W          = 2,
  parameter temp_t MIN_TEMP      = thermal_pkg::MIN_TEMP,
  parameter temp_t ALARM_TEMP    = thermal_pkg::ALARM_TEMP,
  parameter temp_t SHUTDOWN_TEMP = thermal_pkg::SHUTDOWN_TEMP,
  parameter int    PERSIST       = 3,
  parameter int    GAP_CYC       = 16,
  parameter int    TIMEOUT_CYC   = 64,
  parameter temp_t HYST          = 8'd10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              adc_start,
  output logic [CH_W-1:0]   adc_ch,
  input  logic              adc_done,
  input  logic [7:0]        adc_data,
  output logic [7:0]        temp_out,
  output logic [CH_W-1:0]   temp_ch,
  output logic              temp_valid,
  output logic              underrange,
  output logic              alarm,
  output logic [NUM_CH-1:0] alarm_mask,
  output logic              shutdown,
  output logic              timeout_err
);

  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t          state;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] next_ptr;
  logic [CNT_W-1:0] cnt;
  logic            ev_done;
  logic            ev_shut;
  logic            ev_hit;

  // Accepted conversion and its shutdown/non-shutdown split.
  always_comb begin
    ev_done  = (state == WAIT) && adc_done;
    ev_shut  = ev_done && (adc_data >= SHUTDOWN_TEMP);
    ev_hit   = ev_done && (adc_data < SHUTDOWN_TEMP);
    next_ptr = (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + 1'b1;
  end

  assign adc_start = (state == START);
  assign adc_ch    = ptr;
  assign alarm     = (|alarm_mask) && !shutdown;

  // Scan FSM, sample classification and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      temp_out    <= '0;
      temp_ch     <= '0;
      temp_valid  <= 1'b0;
      underrange  <= 1'b0;
      shutdown    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      underrange <= 1'b0;
      case (state)
        IDLE: if (enable && !shutdown) state <= START;
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done on the terminal count wins over the timeout.
          if (adc_done) begin
            state <= EVAL;
            if (adc_data >= SHUTDOWN_TEMP) begin
              shutdown <= 1'b1;
            end else if (adc_data >= MIN_TEMP) begin
              temp_out   <= adc_data;
              temp_ch    <= ptr;
              temp_valid <= 1'b1;
            end else begin
              underrange <= 1'b1;
            end
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            ptr         <= next_ptr;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EVAL: begin
          ptr   <= next_ptr;
          cnt   <= '0;
          state <= GAP;
        end
        GAP: begin
          if (shutdown)                            state <= IDLE;
          else if (cnt == CNT_W'(GAP_CYC - 1))     state <= enable ? START : IDLE;
          else                                     cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    thermal_ch_monitor #(
      .MIN_TEMP   (MIN_TEMP),
      .ALARM_TEMP (ALARM_TEMP),
      .PERSIST    (PERSIST),
      .HYST       (HYST)
    ) u_mon (
      .clk    (clk),
      .rst    (rst),
      .hit    (ev_hit && (ptr == CH_W'(i))),
      .clr    (ev_shut),
      .sample (adc_data),
      .flag   (alarm_mask[i])
    );
  end

endmodule

// File: tb/tb_thermal_scan_sequencer.sv
// Directed self-checking bench for thermal_scan_sequencer (default parameters).
module tb_thermal_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       adc_start;
  logic [1:0] adc_ch;
  logic       adc_done;
  logic [7:0] adc_data;
  logic [7:0] temp_out;
  logic [1:0] temp_ch;
  logic       temp_valid;
  logic       underrange;
  logic       alarm;
  logic [3:0] alarm_mask;
  logic       shutdown;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_start = 0;

  thermal_scan_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .adc_start   (adc_start),
    .adc_ch      (adc_ch),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .temp_out    (temp_out),
    .temp_ch     (temp_ch),
    .temp_valid  (temp_valid),
    .underrange  (underrange),
    .alarm       (alarm),
    .alarm_mask  (alarm_mask),
    .shutdown    (shutdown),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used for start-to-start periods.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a START cycle; check channel and optional period.
  task automatic wait_start(input logic [1:0] ch, input int per);
    int n = 0;
    while (!adc_start && n < 300) begin
      step();
      n++;
    end
    chk("start_seen", 32'(adc_start), 32'd1);
    chk("adc_ch", 32'(adc_ch), 32'(ch));
    if (per != 0) chk("period", 32'(cyc - last_start), 32'(per));
    last_start = cyc;
  endtask

  // One conversion: done in the dly-th WAIT cycle; returns in the EVAL cycle.
  task automatic conv(input logic [1:0] ch, input logic [7:0] d, input int dly, input int per);
    wait_start(ch, per);
    repeat (dly) step();
    adc_data = d;
    adc_done = 1'b1;
    step();
    adc_done = 1'b0;
  endtask

  task automatic count_starts(input int ncyc, output int starts);
    starts = 0;
    for (int k = 0; k < ncyc; k++) begin
      step();
      if (adc_start) starts++;
    end
  endtask

  initial begin
    int starts;
    logic [1:0] order [3];
    order[0] = 2'd3; order[1] = 2'd0; order[2] = 2'd1;

    rst = 1'b1; enable = 1'b0; adc_done = 1'b0; adc_data = 8'd0;
    step(); step();
    // reset state
    chk("rst_start", 32'(adc_start), 32'd0);
    chk("rst_temp_out", 32'(temp_out), 32'd0);
    chk("rst_flags", 32'({temp_valid, underrange, alarm, alarm_mask, shutdown, timeout_err}), 32'd0);
    rst = 1'b0; enable = 1'b1;
    chk("idle_no_start", 32'(adc_start), 32'd0);
    step();
    chk("first_start", 32'(adc_start), 32'd1);
    chk("first_ch", 32'(adc_ch), 32'd0);

    // round-robin scan, period 1+3+1+16
    conv(2'd0, 8'd150, 3, 0);
    chk("rr_valid", 32'(temp_valid), 32'd1);
    chk("rr_temp", 32'(temp_out), 32'd150);
    for (int c = 1; c <= 4; c++) begin
      conv(2'(c % 4), 8'd150, 3, 21);
      chk("rr_valid_n", 32'(temp_valid), 32'd1);
      chk("rr_ch_n", 32'(temp_ch), 32'(c % 4));
    end

    // alarm persistence on channel 2
    conv(2'd1, 8'd120, 3, 21);
    conv(2'd2, 8'd200, 3, 21);
    chk("persist1_alarm", 32'(alarm), 32'd0);
    for (int k = 0; k < 3; k++) conv(order[k], 8'd120, 3, 21);
    conv(2'd2, 8'd200, 3, 21);
    chk("persist2_alarm", 32'(alarm), 32'd0);
    for (int k = 0; k < 3; k++) conv(order[k], 8'd120, 3, 21);
    conv(2'd2, 8'd200, 3, 21);
    chk("persist3_alarm", 32'(alarm), 32'd1);
    chk("persist3_mask", 32'(alarm_mask), 32'h4);
    chk("alarm_temp", 32'(temp_out), 32'd200);
    for (int k = 0; k < 3; k++) conv(order[k], 8'd120, 3, 21);
    chk("alarm_held", 32'(alarm), 32'd1);
    conv(2'd2, 8'd195, 3, 21);
`ifdef THERM_HYST_EN
    chk("hyst_hold", 32'(alarm_mask), 32'h4);
    for (int k = 0; k < 3; k++) conv(order[k], 8'd120, 3, 21);
    conv(2'd2, 8'd189, 3, 21);
    chk("hyst_clear", 32'(alarm_mask), 32'h0);
`else
    chk("alarm_clear", 32'(alarm_mask), 32'h0);
    chk("alarm_clear_or", 32'(alarm), 32'd0);
`endif
    // raise again, then shut down
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) conv(order[k], 8'd120, 3, 21);
      conv(2'd2, 8'd200, 3, 21);
    end
    chk("re_alarm", 32'(alarm), 32'd1);
    conv(2'd3, 8'd120, 3, 21);
    conv(2'd0, 8'd120, 3, 21);
    conv(2'd1, 8'd250, 3, 21);
    chk("sd_set", 32'(shutdown), 32'd1);
    chk("sd_alarm", 32'(alarm), 32'd0);
    chk("sd_mask", 32'(alarm_mask), 32'h0);
    chk("sd_no_valid", 32'(temp_valid), 32'd0);
    chk("sd_temp_held", 32'(temp_out), 32'd120);
    count_starts(100, starts);
    chk("sd_no_start", 32'(starts), 32'd0);
    chk("sd_sticky", 32'(shutdown), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("sd_rst", 32'(shutdown), 32'd0);

    // timeout on channel 3
    conv(2'd0, 8'd150, 3, 0);
    conv(2'd1, 8'd150, 3, 21);
    conv(2'd2, 8'd150, 3, 21);
    wait_start(2'd3, 21);
    repeat (64) step();
    chk("to_before", 32'(timeout_err), 32'd0);
    step();
    chk("to_set", 32'(timeout_err), 32'd1);
    conv(2'd0, 8'd150, 3, 81);
    chk("to_next_valid", 32'(temp_valid), 32'd1);
    chk("to_sticky", 32'(timeout_err), 32'd1);

    // done on the terminal WAIT cycle is accepted
    rst = 1'b1; step(); rst = 1'b0;
    chk("to_rst", 32'(timeout_err), 32'd0);
    conv(2'd0, 8'd150, 64, 0);
    chk("term_valid", 32'(temp_valid), 32'd1);
    chk("term_no_err", 32'(timeout_err), 32'd0);

    // under-range edge
    conv(2'd1, 8'd99, 3, 82);
    chk("ur_pulse", 32'(underrange), 32'd1);
    chk("ur_no_valid", 32'(temp_valid), 32'd0);
    chk("ur_held", 32'(temp_out), 32'd150);
    conv(2'd2, 8'd100, 3, 21);
    chk("min_valid", 32'(temp_valid), 32'd1);
    chk("min_temp", 32'(temp_out), 32'd100);
    chk("min_no_ur", 32'(underrange), 32'd0);

    // reset mid-WAIT, then a late done
    wait_start(2'd3, 21);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    adc_data = 8'd150; adc_done = 1'b1;
    step();
    adc_done = 1'b0;
    chk("late_no_valid", 32'(temp_valid), 32'd0);
    chk("late_temp", 32'(temp_out), 32'd0);

    // enable drop mid-conversion completes then parks
    wait_start(2'd0, 0);
    enable = 1'b0;
    conv(2'd0, 8'd160, 3, 0);
    chk("en_drop_valid", 32'(temp_valid), 32'd1);
    chk("en_drop_temp", 32'(temp_out), 32'd160);
    count_starts(60, starts);
    chk("en_drop_park", 32'(starts), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thermal_scan_sequencer.md
Name: thermal_scan_sequencer

Overview:
- Sequences one shared 8-bit ADC across NUM_CH temperature sensors in round-robin order, using a start/done handshake.
- Classifies every sample against min/alarm/shutdown thresholds, with per-channel alarm persistence.
- Drives the registered temperature output, the alarm, a sticky shutdown and a conversion-timeout flag.
- Sits between the ADC interface and the system thermal-protection logic, upstream of any cooling/shutdown actuation.

Parameters:
- NUM_CH, 4, number of sensor channels scanned (2..8).
- CH_W, 2, channel index width, equal to clog2(NUM_CH).
- MIN_TEMP, 8'd100, samples below this are under-range.
- ALARM_TEMP, 8'd200, alarm threshold (inclusive).
- SHUTDOWN_TEMP, 8'd250, shutdown threshold (inclusive).
- PERSIST, 3, consecutive at-or-above-alarm samples per channel needed to raise that channel's alarm.
- GAP_CYC, 16, idle cycles after each conversion before the next start.
- TIMEOUT_CYC, 64, maximum cycles spent waiting for adc_done.
- HYST, 8'd10, alarm hysteresis band (used only with THERM_HYST_EN).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scanning runs while high.
- adc_start  out  1  one-cycle conversion request.
- adc_ch  out  CH_W  channel select; stable from adc_start until done/timeout.
- adc_done  in  1  one-cycle pulse; adc_data valid in the same cycle.
- adc_data  in  8  conversion result, unsigned.
- temp_out  out  8  last in-range sample.
- temp_ch  out  CH_W  channel of temp_out.
- temp_valid  out  1  one-cycle pulse when temp_out/temp_ch update.
- underrange  out  1  one-cycle pulse when a sample is below MIN_TEMP.
- alarm  out  1  OR of the per-channel alarm flags, forced 0 while shutdown=1.
- alarm_mask  out  NUM_CH  per-channel alarm flags.
- shutdown  out  1  sticky; set by any sample >= SHUTDOWN_TEMP.
- timeout_err  out  1  sticky; set by any conversion timeout.

Behaviour:
- Reset: rst is sampled on posedge clk. It clears every output to 0, sets state to IDLE, sets channel pointer to 0, and clears all counters and flags. A reset during WAIT abandons the conversion; a late adc_done is then ignored because state is IDLE.
- IDLE: stay while enable=0 or shutdown=1. Otherwise go to START.
- START (1 cycle): adc_start=1 and adc_ch=pointer. Load the timeout counter. Go to WAIT.
- WAIT:
  - adc_done=1: register adc_data and go to EVAL.
  - Timeout counter reaches TIMEOUT_CYC with no done: set timeout_err, leave that channel's flags unchanged, advance the pointer, go to GAP.
  - adc_done arriving in the same cycle as the terminal count takes priority over the timeout.
- EVAL (1 cycle), sample s on channel c:
  - s >= SHUTDOWN_TEMP: shutdown<=1, alarm_mask<=0, no temp_valid.
  - MIN_TEMP <= s < SHUTDOWN_TEMP: temp_out<=s, temp_ch<=c, temp_valid pulses.
    - If s >= ALARM_TEMP: persist[c] increments, saturating at PERSIST. alarm_mask[c] is set when persist[c] reaches PERSIST.
    - Otherwise: persist[c]<=0 and alarm_mask[c] clears.
  - s < MIN_TEMP: underrange pulses, persist[c]<=0, alarm_mask[c] clears, temp_out is held.
  - Advance the pointer, wrapping from NUM_CH-1 to 0. Go to GAP.
- GAP: count GAP_CYC cycles, then go to START if enable=1, else IDLE. When shutdown=1, go to IDLE immediately.
- Latency: temp_valid occurs exactly 1 cycle after the adc_done cycle. Start-to-start period is 1 + conversion cycles + 1 + GAP_CYC.
- Boundaries:
  - Both thresholds are inclusive: 200 counts as alarm, 250 counts as shutdown.
  - enable dropping mid-conversion still completes the conversion and EVAL, then the block parks in IDLE.
  - shutdown and timeout_err clear only on rst.
  - An adc_done pulse outside WAIT is ignored.

Optional Feature:
- Macro THERM_HYST_EN.
- Defined: once alarm_mask[c] is set, it clears only on an in-range sample below ALARM_TEMP-HYST, or on an under-range sample. Samples in ALARM_TEMP-HYST .. ALARM_TEMP-1 hold both the flag and persist[c].
- Undefined: the flag clears on the first sample below ALARM_TEMP, as in the base behaviour.

Decomposition:
- Shared package thermal_pkg holds:
  - the state enum (IDLE, START, WAIT, EVAL, GAP);
  - the temp_t 8-bit typedef;
  - default threshold constants MIN_TEMP, ALARM_TEMP, SHUTDOWN_TEMP.
- One natural sub-module, thermal_ch_monitor, instantiated NUM_CH times. It holds the persistence counter and alarm flag (plus hysteresis when enabled) and is updated by an eval strobe qualified by channel match.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then enable=1. Expect adc_start on the 2nd cycle after rst falls and adc_ch=0; all outputs 0 before that.
- Round-robin scan: NUM_CH=4, model replies 150 after 3 cycles. Expect adc_ch 0,1,2,3,0, temp_valid once per conversion with temp_out=150, and start-to-start period of 1+3+1+16=21 cycles.
- Alarm persistence: channel 2 returns 200 three times, the others return 120. Expect alarm rising in the EVAL after the 3rd sample on channel 2, alarm_mask=4'b0100, and clearing after channel 2 returns 195 (hysteresis off). With THERM_HYST_EN, 195 holds the alarm and 189 clears it.
- Shutdown: channel 1 returns 250 while alarm=1. Expect shutdown=1, alarm=0, no further adc_start, and state held until rst.
- Timeout: the model never responds on channel 3. Expect timeout_err=1 after 64 WAIT cycles and the next start on channel 0. Separately, adc_done arriving on the terminal cycle is accepted with no error.
- Under-range/edges: samples 99 and 100. Expect underrange pulse with temp_out held for 99, and temp_valid with temp_out=100. A reset asserted mid-WAIT followed by a late adc_done produces no temp_valid.
